// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: writes a streamed program into memory, then releases the core.
// Optional checksum verification stage is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
   parameter int N     = 32,
   parameter int DEPTH = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   ld_valid,
   input  logic [N-1:0]           ld_data,
   input  logic                   ld_last,
   output logic                   ld_ready,
   output logic                   mem_we,
   output logic [N-1:0]           mem_addr,
   output logic [N-1:0]           mem_wd,
   output logic                   core_run,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [$clog2(DEPTH):0] word_count
);
   localparam int CW = $clog2(DEPTH) + 1;

`ifdef IMEM_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHK, S_FLUSH, S_RUN, S_ERR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_ERR} state_t;
`endif

   state_t        r_state, w_state_nxt;
   logic          r_flush_cnt;
   logic [CW-1:0] r_word_count;
   logic          r_ld_ready, r_mem_we, r_core_run, r_busy, r_done, r_err;
   logic [N-1:0]  r_mem_addr, r_mem_wd;
   logic          w_accept, w_full, w_write, w_restart;

   assign w_accept  = ld_valid & r_ld_ready;
   assign w_full    = (r_word_count == CW'(DEPTH));
   assign w_write   = w_accept & (r_state == S_LOAD) & ~w_full;
   assign w_restart = start & ((r_state == S_IDLE) | (r_state == S_RUN));

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [N-1:0] r_csum;
   logic         w_csum_ok;
   assign w_csum_ok = (ld_data == r_csum);
`endif

   // NOTE: every variable in always_comb gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (w_accept) begin
               if (w_full)
                  w_state_nxt = S_ERR;
               else if (ld_last)
`ifdef IMEM_LOAD_CHECKSUM_EN
                  w_state_nxt = S_CHK;
`else
                  w_state_nxt = S_FLUSH;
`endif
            end
         end
`ifdef IMEM_LOAD_CHECKSUM_EN
         S_CHK:   if (w_accept) w_state_nxt = w_csum_ok ? S_FLUSH : S_ERR;
`endif
         S_FLUSH: if (r_flush_cnt) w_state_nxt = S_RUN;
         S_RUN:   if (start) w_state_nxt = S_LOAD;
         S_ERR:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_flush_cnt  <= 1'b0;
         r_word_count <= '0;
         r_ld_ready   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wd     <= '0;
         r_core_run   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         r_csum       <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= (r_state == S_FLUSH) ? ~r_flush_cnt : 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         r_ld_ready  <= (w_state_nxt == S_LOAD) | (w_state_nxt == S_CHK);
         r_busy      <= (w_state_nxt == S_LOAD) | (w_state_nxt == S_CHK) | (w_state_nxt == S_FLUSH);
`else
         r_ld_ready  <= (w_state_nxt == S_LOAD);
         r_busy      <= (w_state_nxt == S_LOAD) | (w_state_nxt == S_FLUSH);
`endif
         r_core_run  <= (w_state_nxt == S_RUN);
         r_done      <= (w_state_nxt == S_RUN);
         r_err       <= (w_state_nxt == S_ERR);
         r_mem_we    <= w_write;

         // Address uses the pre-increment count; an overflowing word is never written.
         if (w_restart) begin
            r_word_count <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_csum       <= '0;
`endif
         end else if (w_write) begin
            r_mem_addr   <= N'(r_word_count) << 2;
            r_mem_wd     <= ld_data;
            r_word_count <= r_word_count + CW'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_csum       <= r_csum + ld_data;
`endif
         end
      end
   end

   assign ld_ready   = r_ld_ready;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wd     = r_mem_wd;
   assign core_run   = r_core_run;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl (DEPTH=4); checksum cases compile in with IMEM_LOAD_CHECKSUM_EN.
module tb_imem_load_ctrl;
   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst, start, ld_valid, ld_last;
   logic [N-1:0]  ld_data;
   logic          ld_ready, mem_we, core_run, busy, done, err;
   logic [N-1:0]  mem_addr, mem_wd;
   logic [CW-1:0] word_count;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] wr_addr_q[$];
   logic [N-1:0] wr_data_q[$];

   imem_load_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .core_run   (core_run),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Memory-side log of every issued write, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wd);
      end
   end

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [N-1:0] d, input logic l);
      ld_valid = v;
      ld_data  = d;
      ld_last  = l;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ld_ready"}, ld_ready, '0);
      check({tag, "_mem_we"}, mem_we, '0);
      check({tag, "_mem_addr"}, mem_addr, '0);
      check({tag, "_mem_wd"}, mem_wd, '0);
      check({tag, "_core_run"}, core_run, '0);
      check({tag, "_busy"}, busy, '0);
      check({tag, "_done"}, done, '0);
      check({tag, "_err"}, err, '0);
      check({tag, "_word_count"}, N'(word_count), '0);
   endtask

   // Called in the first cycle after the final acceptance; core_run must rise in the third.
   task automatic expect_run(input string tag);
      check({tag, "_c1_core_run"}, core_run, '0);
      check({tag, "_c1_busy"}, busy, 1);
      tick();
      check({tag, "_c2_core_run"}, core_run, '0);
      check({tag, "_c2_mem_we"}, mem_we, '0);
      tick();
      check({tag, "_c3_core_run"}, core_run, 1);
      check({tag, "_c3_done"}, done, 1);
      check({tag, "_c3_busy"}, busy, '0);
      check({tag, "_c3_ld_ready"}, ld_ready, '0);
   endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
   task automatic send_csum(input logic [N-1:0] c);
      drive(1'b1, c, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      check("csum_not_written", mem_we, '0);
   endtask
`endif

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      drive(1'b0, '0, 1'b0);
      tick();
      tick();
      check_all_zero("rst_hold");
      rst = 1'b0;
      tick();
      check_all_zero("idle");

      // Back-to-back two-word load.
      wr_addr_q.delete();
      wr_data_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("a_ld_ready", ld_ready, 1);
      check("a_busy", busy, 1);
      check("a_wc0", N'(word_count), '0);
      drive(1'b1, 32'hFFC4A303, 1'b0);
      tick();
      check("a_we0", mem_we, 1);
      check("a_addr0", mem_addr, 32'h0);
      check("a_wd0", mem_wd, 32'hFFC4A303);
      check("a_wc1", N'(word_count), 1);
      drive(1'b1, 32'h00832383, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("a_we1", mem_we, 1);
      check("a_addr1", mem_addr, 32'h4);
      check("a_wd1", mem_wd, 32'h00832383);
      check("a_wc2", N'(word_count), 2);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_csum(32'h0047C686);
`endif
      expect_run("a");
      check("a_log_n", wr_addr_q.size(), 2);
      check("a_log_a0", wr_addr_q[0], 32'h0);
      check("a_log_d0", wr_data_q[0], 32'hFFC4A303);
      check("a_log_a1", wr_addr_q[1], 32'h4);
      check("a_log_d1", wr_data_q[1], 32'h00832383);
      check("a_wc_run", N'(word_count), 2);

      // Load inputs are ignored while running.
      drive(1'b1, 32'h12345678, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("run_ignore_we", mem_we, '0);
      check("run_ignore_wc", N'(word_count), 2);

      // Restart from RUN, reload with gaps between words.
      wr_addr_q.delete();
      wr_data_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("f_core_run", core_run, '0);
      check("f_wc0", N'(word_count), '0);
      check("f_ld_ready", ld_ready, 1);
      drive(1'b1, 32'hFFC4A303, 1'b0);
      tick();
      check("g_we0", mem_we, 1);
      check("g_addr0", mem_addr, 32'h0);
      drive(1'b0, 32'hDEADBEEF, 1'b1);
      tick();
      check("g_gap_we", mem_we, '0);
      check("g_gap_wc", N'(word_count), 1);
      check("g_gap_busy", busy, 1);
      drive(1'b1, 32'h00832383, 1'b1);
      tick();
      drive(1'b0, '0, 1'b0);
      check("g_we1", mem_we, 1);
      check("g_addr1", mem_addr, 32'h4);
      check("g_wd1", mem_wd, 32'h00832383);
      check("g_wc2", N'(word_count), 2);
`ifdef IMEM_LOAD_CHECKSUM_EN
      send_csum(32'h0047C686);
`endif
      expect_run("g");
      check("g_log_n", wr_addr_q.size(), 2);
      check("g_log_a0", wr_addr_q[0], 32'h0);
      check("g_log_d0", wr_data_q[0], 32'hFFC4A303);
      check("g_log_a1", wr_addr_q[1], 32'h4);
      check("g_log_d1", wr_data_q[1], 32'h00832383);

      // Overflow: five words into a four-word memory.
      wr_addr_q.delete();
      wr_data_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'hA0 + i, 1'b0);
         tick();
         check($sformatf("ovf_we%0d", i), mem_we, 1);
         check($sformatf("ovf_addr%0d", i), mem_addr, 4 * i);
         check($sformatf("ovf_wc%0d", i), N'(word_count), i + 1);
      end
      drive(1'b1, 32'hA4, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0);
      check("ovf_no_we", mem_we, '0);
      check("ovf_err", err, 1);
      check("ovf_wc", N'(word_count), 4);
      check("ovf_ld_ready", ld_ready, '0);
      check("ovf_busy", busy, '0);
      start = 1'b1;
      drive(1'b1, 32'hA5, 1'b1);
      tick();
      start = 1'b0;
      drive(1'b0, '0, 1'b0);
      check("err_sticky", err, 1);
      check("err_no_run", core_run, '0);
      check("ovf_log_n", wr_addr_q.size(), 4);
      check("ovf_log_a3", wr_addr_q[3], 32'hC);
      check("ovf_log_d3", wr_data_q[3], 32'hA3);

      // Reset mid-load, with a word presented at the reset edge.
      rst = 1'b1;
      tick();
      check_all_zero("rst_err");
      rst = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      drive(1'b1, 32'h11, 1'b0);
      tick();
      check("mid_we", mem_we, 1);
      drive(1'b1, 32'h22, 1'b0);
      rst = 1'b1;
      tick();
      check_all_zero("rst_mid");
      rst = 1'b0;
      drive(1'b1, 32'h33, 1'b1);
      tick();
      check("post_rst_we", mem_we, '0);
      check("post_rst_ready", ld_ready, '0);
      tick();
      drive(1'b0, '0, 1'b0);
      check("post_rst_wc", N'(word_count), '0);
      check("post_rst_log_n", wr_addr_q.size(), 1);

`ifdef IMEM_LOAD_CHECKSUM_EN
      // Checksum match then mismatch.
      start = 1'b1;
      tick();
      start = 1'b0;
      drive(1'b1, 32'h1, 1'b0);
      tick();
      drive(1'b1, 32'h2, 1'b1);
      tick();
      check("cs_chk_ready", ld_ready, 1);
      send_csum(32'h3);
      expect_run("cs_ok");
      start = 1'b1;
      tick();
      start = 1'b0;
      drive(1'b1, 32'h1, 1'b0);
      tick();
      drive(1'b1, 32'h2, 1'b1);
      tick();
      send_csum(32'h4);
      check("cs_bad_err", err, 1);
      check("cs_bad_core_run", core_run, '0);
      check("cs_bad_ld_ready", ld_ready, '0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024: instruction memory capacity in words.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a program load.
REQ-006 SHALL have port ld_valid, input, 1 bit: ld_data holds a valid instruction word.
REQ-007 SHALL have port ld_data, input, N bits: instruction word to store.
REQ-008 SHALL have port ld_last, input, 1 bit: qualifies the final word of the program.
REQ-009 SHALL have port ld_ready, output, 1 bit: controller accepts a word this cycle.
REQ-010 SHALL have port mem_we, output, 1 bit: one-cycle write strobe to instruction memory.
REQ-011 SHALL have port mem_addr, output, N bits: byte address of the write, word-aligned, bits [1:0] = 00.
REQ-012 SHALL have port mem_wd, output, N bits: write data.
REQ-013 SHALL have port core_run, output, 1 bit: high releases the core and enables memory reads; low holds them.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD, CHK or FLUSH.
REQ-015 SHALL have port done, output, 1 bit: high in RUN.
REQ-016 SHALL have port err, output, 1 bit: high in ERR.
REQ-017 SHALL have port word_count, output, $clog2(DEPTH)+1 bits: number of words written in the current load.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, CHK, FLUSH, RUN and ERR, one-hot or binary.
REQ-019 In IDLE, SHALL go to LOAD when start=1, clearing word_count.
REQ-020 SHALL assert ld_ready only in LOAD and CHK, and SHALL accept a word when ld_valid and ld_ready are both high.
REQ-021 SHALL, on a word accepted in LOAD, assert mem_we for exactly the following cycle, with mem_addr = word_count*4 (pre-increment) and mem_wd = the accepted ld_data, and SHALL increment word_count.
REQ-022 SHALL keep mem_we at 0 in every cycle that does not follow an acceptance.
REQ-023 SHALL, on an accepted word with ld_last=1, go to CHK when the macro is defined, otherwise to FLUSH.
REQ-024 SHALL, when a word is accepted in LOAD while word_count==DEPTH, go to ERR, not write that word, and hold word_count.
REQ-025 SHALL stay in FLUSH for exactly 2 cycles and then go to RUN.
REQ-026 SHALL drive core_run=1 only in RUN.
REQ-027 SHALL, on start=1 in RUN, drop core_run the next cycle and go to LOAD with word_count cleared.
REQ-028 SHALL ignore start in LOAD, CHK, FLUSH and ERR.
REQ-029 SHALL keep ERR until rst, with ld_ready=0.
REQ-030 SHALL ignore ld_valid, ld_data and ld_last outside LOAD and CHK.

Reset
REQ-031 SHALL, on a rising clk edge with rst=1, enter IDLE regardless of current state, including mid-load.
REQ-032 SHALL, during and immediately after reset, hold all outputs at 0: ld_ready, mem_we, mem_addr, mem_wd, core_run, busy, done, err, word_count and the internal checksum.
REQ-033 SHALL drop any write pending at the reset edge; it is never issued.

Configuration
REQ-034 SHALL, with IMEM_LOAD_CHECKSUM_EN defined, keep a running N-bit modulo-2^N sum of words accepted in LOAD; in CHK, accept one more word as the checksum (never written to memory) and go to FLUSH on a match, ERR on a mismatch.
REQ-035 SHALL, with IMEM_LOAD_CHECKSUM_EN undefined, contain no CHK state and no checksum logic, and go from LOAD on ld_last directly to FLUSH.

Verification
REQ-036 The bench SHALL cover: after reset, start, then words 0xFFC4A303 and 0x00832383 (last) on back-to-back cycles -> mem_we pulses at addr 0x0 then 0x4 with matching data, word_count=2, core_run=1 exactly 3 cycles after the last acceptance.
REQ-037 The bench SHALL cover: the same load with ld_valid low on alternate cycles -> identical writes, no mem_we in the gap cycles.
REQ-038 The bench SHALL cover: DEPTH=4 with 5 words and no ld_last -> 4 writes at 0x0 to 0xC, err=1, no fifth write, word_count=4.
REQ-039 The bench SHALL cover: rst=1 after 1 accepted word of 3 -> IDLE, all outputs 0, no further mem_we.
REQ-040 The bench SHALL cover: with IMEM_LOAD_CHECKSUM_EN, words 0x1 and 0x2 (last), then checksum 0x3 -> RUN; repeated with checksum 0x4 -> err=1 and core_run=0.
REQ-041 The bench SHALL cover: start in RUN -> core_run=0 the next cycle, word_count=0, reload writes from addr 0x0.
